// File: rtl/dmem_sync.sv
// Clocked single-port data memory with byte-lane writes, registered reads,
// req/ready handshake, address range checking and a zeroing sweep after reset.
module dmem_sync #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   byteEn,
  input  logic [DATA_W-1:0]     writeData,
  output logic                  ready,
  output logic [DATA_W-1:0]     readData,
  output logic                  readValid,
  output logic                  addrError
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              aerr_q, aerr_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              in_range;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_be;

  assign ready    = (state_q == S_RUN);
  assign accept   = req && ready;
  assign in_range = ({1'b0, addr} < DEPTH_L);

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    aerr_d    = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = clr_ptr_q;
    wr_data   = '0;
    wr_be     = '1;
    unique case (state_q)
      S_CLEAR: begin
        // zero one word per cycle; pointer parks on the last word
        wr_en = 1'b1;
        if (clr_ptr_q == LAST) begin
          state_d = S_RUN;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      S_RUN: begin
        if (accept) begin
          aerr_d = !in_range;
          if (we) begin
            wr_en   = in_range;
            wr_addr = addr;
            wr_data = writeData;
            wr_be   = byteEn;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = in_range ? mem_q[addr]
                                : '0;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      aerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      aerr_q    <= aerr_d;
    end
  end

  // array has no reset; the CLEAR sweep zeroes it
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign readData  = rdata_q;
  assign readValid = rvalid_q;
  assign addrError = aerr_q;

endmodule

// File: tb/tb_dmem_sync.sv
// Bench for dmem_sync: a DEPTH=512 and a DEPTH=300 instance share stimulus
// and are checked against per-instance word-array models.
module tb_dmem_sync;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [8:0]  addr = '0;
  logic [3:0]  byteEn = '0;
  logic [31:0] writeData = '0;

  logic        ready_a, rv_a, ae_a;
  logic [31:0] rd_a;
  logic        ready_b, rv_b, ae_b;
  logic [31:0] rd_b;

  logic [31:0] mA [512];
  logic [31:0] mB [300];
  logic        ea_rv, ea_ae, eb_rv, eb_ae;
  logic [31:0] ea_rd, eb_rd;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_sync #(.DATA_W(32), .DEPTH(512), .ADDR_W(9)) u_a (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr(addr), .byteEn(byteEn), .writeData(writeData),
    .ready(ready_a), .readData(rd_a),
    .readValid(rv_a), .addrError(ae_a)
  );

  dmem_sync #(.DATA_W(32), .DEPTH(300), .ADDR_W(9)) u_b (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr(addr), .byteEn(byteEn), .writeData(writeData),
    .ready(ready_b), .readData(rd_b),
    .readValid(rv_b), .addrError(ae_b)
  );

  task automatic model_clear();
    for (int i = 0; i < 512; i++) mA[i] = '0;
    for (int i = 0; i < 300; i++) mB[i] = '0;
    ea_rd = '0; eb_rd = '0;
    ea_rv = 0; ea_ae = 0; eb_rv = 0; eb_ae = 0;
  endtask

  // one access in RUN; expectations come from the models
  task automatic drive(input logic r, input logic w,
                       input logic [8:0] a, input logic [3:0] be,
                       input logic [31:0] d);
    @(negedge clk);
    req = r; we = w; addr = a; byteEn = be; writeData = d;
    ea_rv = 0; ea_ae = 0; eb_rv = 0; eb_ae = 0;
    if (r) begin
      eb_ae = (a >= 300);
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mA[a][8*i +: 8] = d[8*i +: 8];
            if (a < 300) mB[a][8*i +: 8] = d[8*i +: 8];
          end
        end
      end else begin
        ea_rv = 1; ea_rd = mA[a];
        eb_rv = 1; eb_rd = (a < 300) ? mB[a] : 32'h0;
      end
    end
    @(posedge clk); #1;
    req = 0;
  endtask

  // release reset and count ready-low cycles; optionally poke a write at cycle 10
  task automatic release_reset(input bit inject,
                               output int ca, output int cb);
    @(negedge clk);
    reset = 0; ca = 0; cb = 0;
    model_clear();
    for (int k = 0; k < 2000; k++) begin
      if (ready_a) break;
      ca++;
      if (!ready_b) cb++;
      if (inject && k == 10) begin
        req = 1; we = 1; addr = 9'd7;
        byteEn = 4'hF; writeData = 32'h12345678;
      end else begin
        req = 0;
      end
      @(posedge clk); #1;
    end
    req = 0;
  endtask

  task automatic test_reset();
    int ca, cb;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready got a=%b b=%b exp 0", ready_a, ready_b);
    end
    n_chk++;
    if ({rv_a, ae_a, rv_b, ae_b} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_flags got %b exp 0000", {rv_a, ae_a, rv_b, ae_b});
    end
    n_chk++;
    if (rd_a !== 32'h0 || rd_b !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_rdata got %h/%h exp 0", rd_a, rd_b);
    end
    release_reset(0, ca, cb);
    n_chk++;
    if (ca !== 512) begin
      n_fail++;
      $display("FAIL clear_len_a got %0d exp 512", ca);
    end
    n_chk++;
    if (cb !== 300) begin
      n_fail++;
      $display("FAIL clear_len_b got %0d exp 300", cb);
    end
    drive(1, 0, 9'd5, 4'h0, 32'h0);
    n_chk++;
    if (rv_a !== 1'b1 || rd_a !== 32'h0) begin
      n_fail++;
      $display("FAIL rd5 got rv=%b rd=%h exp rv=1 rd=0", rv_a, rd_a);
    end
  endtask

  task automatic test_write_read();
    drive(1, 1, 9'd3, 4'hF, 32'hDEADBEEF);
    n_chk++;
    if (rv_a !== 1'b0 || ae_a !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_flags got rv=%b ae=%b exp 0 0", rv_a, ae_a);
    end
    drive(1, 0, 9'd3, 4'h0, 32'h0);
    n_chk++;
    if (rv_a !== 1'b1 || rd_a !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rd3 got rv=%b rd=%h exp 1 deadbeef", rv_a, rd_a);
    end
    drive(0, 0, 9'd0, 4'h0, 32'h0);
    n_chk++;
    if (rv_a !== 1'b0 || rd_a !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rd3_pulse got rv=%b rd=%h exp 0 deadbeef", rv_a, rd_a);
    end
  endtask

  task automatic test_byte_lanes();
    drive(1, 1, 9'd3, 4'b0010, 32'h0000AA00);
    drive(1, 0, 9'd3, 4'h0, 32'h0);
    n_chk++;
    if (rd_a !== 32'hDEADAAEF || rv_a !== 1'b1) begin
      n_fail++;
      $display("FAIL lane got rv=%b rd=%h exp 1 deadaaef", rv_a, rd_a);
    end
    drive(1, 1, 9'd3, 4'h0, 32'h11111111);
    drive(1, 0, 9'd3, 4'h0, 32'h0);
    n_chk++;
    if (rd_a !== 32'hDEADAAEF) begin
      n_fail++;
      $display("FAIL be0_noop got %h exp deadaaef", rd_a);
    end
  endtask

  task automatic test_range();
    drive(1, 0, 9'd400, 4'h0, 32'h0);
    n_chk++;
    if ({rv_b, ae_b} !== 2'b11 || rd_b !== 32'h0) begin
      n_fail++;
      $display("FAIL oor_rd got rv=%b ae=%b rd=%h exp 1 1 0", rv_b, ae_b, rd_b);
    end
    n_chk++;
    if (ae_a !== 1'b0 || rv_a !== 1'b1) begin
      n_fail++;
      $display("FAIL inr_400 got rv=%b ae=%b exp 1 0", rv_a, ae_a);
    end
    drive(1, 1, 9'd400, 4'hF, 32'hFFFFFFFF);
    n_chk++;
    if ({rv_b, ae_b} !== 2'b01) begin
      n_fail++;
      $display("FAIL oor_wr got rv=%b ae=%b exp 0 1", rv_b, ae_b);
    end
    drive(1, 0, 9'd100, 4'h0, 32'h0);
    n_chk++;
    if (rd_b !== 32'h0 || ae_b !== 1'b0 || rv_b !== 1'b1) begin
      n_fail++;
      $display("FAIL rd100 got rv=%b ae=%b rd=%h exp 1 0 0", rv_b, ae_b, rd_b);
    end
    drive(1, 0, 9'd299, 4'h0, 32'h0);
    n_chk++;
    if (rd_b !== 32'h0 || ae_b !== 1'b0) begin
      n_fail++;
      $display("FAIL rd299 got ae=%b rd=%h exp 0 0", ae_b, rd_b);
    end
    drive(0, 0, 9'd0, 4'h0, 32'h0);
    n_chk++;
    if (ae_b !== 1'b0) begin
      n_fail++;
      $display("FAIL ae_pulse got %b exp 0", ae_b);
    end
  endtask

  task automatic test_reset_mid();
    int ca, cb;
    @(negedge clk);
    req = 1; we = 0; addr = 9'd3; reset = 1;
    #1;
    n_chk++;
    if (ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_ready got %b exp 0", ready_a);
    end
    @(posedge clk); #1;
    n_chk++;
    if (rv_a !== 1'b0 || ready_a !== 1'b0 || rd_a !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_rv got rv=%b rdy=%b rd=%h exp 0 0 0", rv_a, ready_a, rd_a);
    end
    req = 0;
    release_reset(0, ca, cb);
    n_chk++;
    if (ca !== 512) begin
      n_fail++;
      $display("FAIL mid_clear got %0d exp 512", ca);
    end
    drive(1, 0, 9'd3, 4'h0, 32'h0);
    n_chk++;
    if (rd_a !== 32'h0 || rv_a !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rd3 got rv=%b rd=%h exp 1 0", rv_a, rd_a);
    end
  endtask

  task automatic test_clear_drop();
    int ca, cb;
    @(negedge clk);
    reset = 1;
    repeat (2) @(posedge clk);
    release_reset(1, ca, cb);
    n_chk++;
    if (ca !== 512) begin
      n_fail++;
      $display("FAIL drop_clear got %0d exp 512", ca);
    end
    drive(1, 0, 9'd7, 4'h0, 32'h0);
    n_chk++;
    if (rd_a !== 32'h0 || rd_b !== 32'h0) begin
      n_fail++;
      $display("FAIL drop_rd7 got %h/%h exp 0", rd_a, rd_b);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      drive(1, 1, 9'(20 + i), 4'hF, 32'hA5000000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 9'(20 + i), 4'h0, 32'h0);
      n_chk++;
      if (rv_a !== 1'b1 || rd_a !== 32'hA5000000 + 32'(i)) begin
        n_fail++;
        $display("FAIL b2b%0d got rv=%b rd=%h exp 1 %h",
                 i, rv_a, rd_a, 32'hA5000000 + 32'(i));
      end
    end
    drive(1, 1, 9'd30, 4'hF, 32'hCAFEF00D);
    drive(1, 0, 9'd30, 4'h0, 32'h0);
    n_chk++;
    if (rd_a !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL raw got %h exp cafef00d", rd_a);
    end
  endtask

  task automatic test_random();
    logic r, w;
    logic [8:0] a;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 3) != 0);
      w = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 1) ? 9'($urandom_range(0, 7))
                               : 9'($urandom_range(292, 307));
      drive(r, w, a, 4'($urandom), $urandom);
      n_chk++;
      if (rv_a !== ea_rv || ae_a !== ea_ae || rd_a !== ea_rd) begin
        n_fail++;
        $display("FAIL rnd_a%0d got %b%b %h exp %b%b %h",
                 k, rv_a, ae_a, rd_a, ea_rv, ea_ae, ea_rd);
      end
      n_chk++;
      if (rv_b !== eb_rv || ae_b !== eb_ae || rd_b !== eb_rd) begin
        n_fail++;
        $display("FAIL rnd_b%0d got %b%b %h exp %b%b %h",
                 k, rv_b, ae_b, rd_b, eb_rv, eb_ae, eb_rd);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_range();
    test_reset_mid();
    test_clear_drop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
